// File: rtl/decimal_parser_pkg.sv
// Shared types and constants for the decimal operand parser: state encoding,
// ASCII codes, accumulator width and small state-classification helpers.
package decimal_parser_pkg;

  localparam int ACC_W = 7;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [2:0] {
    X_D0, X_D1, X_D2, Y_D0, Y_D1, Y_D2, OUT
  } state_e;

  function automatic int digits_held(input state_e s);
    int n;
    case (s)
      X_D1, Y_D1: n = 1;
      X_D2, Y_D2: n = 2;
      default:    n = 0;
    endcase
    return n;
  endfunction

  function automatic logic is_y_state(input state_e s);
    return (s == Y_D0) || (s == Y_D1) || (s == Y_D2);
  endfunction

  function automatic state_e d0_of(input state_e s);
    return is_y_state(s) ? Y_D0 : X_D0;
  endfunction

  function automatic state_e next_digit_state(input state_e s);
    state_e n;
    case (s)
      X_D0:    n = X_D1;
      X_D1:    n = X_D2;
      Y_D0:    n = Y_D1;
      Y_D1:    n = Y_D2;
      default: n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ascii_digit_decode.sv
// Combinational classifier for one ASCII character: decimal digit, Enter
// (LF or CR), or neither; digit value is the low nibble for '0'..'9'.
module ascii_digit_decode
  import decimal_parser_pkg::*;
(
  input  logic [7:0] char_data,
  output logic       is_digit,
  output logic       is_enter,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = (char_data >= ASCII_0) && (char_data <= ASCII_9);
    is_enter = (char_data == ASCII_LF) || (char_data == ASCII_CR);
    digit    = char_data[3:0];
  end

endmodule

// File: rtl/decimal_operand_parser.sv
// Parses two Enter-terminated decimal operands from an ASCII stream into a
// registered X/Y pair. Macro PARSER_RANGE_CHECK_EN rejects values above 2^WIDTH-1.
//
//   state | meaning
//   X_D0  | X operand, no digits yet
//   X_D1  | X operand, one digit held
//   X_D2  | X operand, two digits held
//   Y_D0  | Y operand, no digits yet (X committed)
//   Y_D1  | Y operand, one digit held
//   Y_D2  | Y operand, two digits held
//   OUT   | pair presented, waiting for op_ready
module decimal_operand_parser
  import decimal_parser_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int MAX_DIGITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_x,
  output logic [WIDTH-1:0] op_y,
  output logic             err
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   op_x_q, op_x_d;
  logic [WIDTH-1:0]   op_y_q, op_y_d;
  logic               err_q, err_d;

  logic               is_digit, is_enter;
  logic [3:0]         digit;
  logic               accept;
  logic               do_error;
  logic               range_bad;

  ascii_digit_decode u_decode (
    .char_data (char_data),
    .is_digit  (is_digit),
    .is_enter  (is_enter),
    .digit     (digit)
  );

  assign accept = char_valid && char_ready;

`ifdef PARSER_RANGE_CHECK_EN
  localparam logic [ACC_W-1:0] OP_MAX = ACC_W'((1 << WIDTH) - 1);
  assign range_bad = (acc_q > OP_MAX);
`else
  assign range_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= X_D0;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      op_x_q <= '0;
      op_y_q <= '0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      op_x_q <= op_x_d;
      op_y_q <= op_y_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    op_x_d   = op_x_q;
    op_y_d   = op_y_q;
    err_d    = 1'b0;
    do_error = 1'b0;
    if (state_q == OUT) begin
      if (op_ready) begin
        state_d = X_D0;
        acc_d   = '0;
      end
    end else if (accept) begin
      if (is_digit) begin
        if (digits_held(state_q) >= MAX_DIGITS) begin
          do_error = 1'b1;
        end else begin
          acc_d   = (digits_held(state_q) == 0) ? ACC_W'(digit)
                                                : acc_q * ACC_W'(10) + ACC_W'(digit);
          state_d = next_digit_state(state_q);
        end
      end else if (is_enter) begin
        // Enter with no digits is a blank line and is silently skipped
        if (digits_held(state_q) != 0) begin
          if (range_bad) begin
            do_error = 1'b1;
          end else if (is_y_state(state_q)) begin
            op_y_d  = acc_q[WIDTH-1:0];
            state_d = OUT;
          end else begin
            op_x_d  = acc_q[WIDTH-1:0];
            acc_d   = '0;
            state_d = Y_D0;
          end
        end
      end else begin
        do_error = 1'b1;
      end
    end
    if (do_error) begin
      err_d   = 1'b1;
      acc_d   = '0;
      state_d = d0_of(state_q);
    end
  end

  always_comb begin
    char_ready = !rst && (state_q != OUT);
    op_valid   = (state_q == OUT);
    op_x       = op_x_q;
    op_y       = op_y_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_decimal_operand_parser.sv
// Scoreboard bench for decimal_operand_parser: directed scenarios plus random
// character streams checked against an integer-arithmetic reference model.
module tb_decimal_operand_parser;

  localparam int WIDTH = 5;
`ifdef PARSER_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             char_valid = 1'b0;
  logic [7:0]       char_data = 8'h00;
  logic             char_ready;
  logic             op_valid;
  logic             op_ready = 1'b0;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             err;

  decimal_operand_parser #(.WIDTH(WIDTH), .MAX_DIGITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_x       (op_x),
    .op_y       (op_y),
    .err        (err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int x;
    int y;
  } ev_t;

  ev_t  exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   hs_cyc = -1;
  int   acc_cyc = -1;
  bit   rand_rdy = 1'b0;

  int   m_val = 0;
  int   m_cnt = 0;
  bit   m_in_y = 1'b0;
  int   m_x = 0;

  logic [7:0] ill [6] = '{8'h41, 8'h20, 8'h2F, 8'h3A, 8'hFF, 8'h00};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_rdy) op_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic m_error();
    ev_t e;
    e.is_err = 1'b1; e.x = 0; e.y = 0;
    exp_q.push_back(e);
    m_val = 0;
    m_cnt = 0;
  endtask

  // Reference: an operand is a string of up to two digits closed by Enter
  task automatic model_char(input logic [7:0] c);
    ev_t e;
    if (c >= 8'h30 && c <= 8'h39) begin
      if (m_cnt >= 2) m_error();
      else begin
        m_val = m_val * 10 + (int'(c) - 48);
        m_cnt++;
      end
    end else if (c == 8'h0A || c == 8'h0D) begin
      if (m_cnt != 0) begin
        if (RANGE_CHECK && m_val > (1 << WIDTH) - 1) m_error();
        else if (!m_in_y) begin
          m_x    = m_val % (1 << WIDTH);
          m_in_y = 1'b1;
          m_val  = 0;
          m_cnt  = 0;
        end else begin
          e.is_err = 1'b0; e.x = m_x; e.y = m_val % (1 << WIDTH);
          exp_q.push_back(e);
          m_in_y = 1'b0;
          m_val  = 0;
          m_cnt  = 0;
        end
      end
    end else begin
      m_error();
    end
  endtask

  // Called at posedge+2; returns at posedge+2 of the cycle after acceptance
  task automatic send_char(input logic [7:0] c);
    int waited;
    waited = 0;
    char_valid = 1'b1;
    char_data  = c;
    while (!char_ready && waited < 40) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (char_ready) begin
      model_char(c);
      acc_cyc = cyc;
      @(posedge clk);
      #2;
    end else begin
      n_vec++;
      n_miss++;
      $display("FAIL char_accept_timeout: char_ready 0 for 40 cycles, required 1");
    end
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_char_ready", char_ready, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_x", op_x, 0);
    check("rst_op_y", op_y, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    m_val = 0; m_cnt = 0; m_in_y = 1'b0; m_x = 0;
    #1;
    check("post_rst_char_ready", char_ready, 1);
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12)      return 8'h30 + 8'($urandom_range(0, 9));
    else if (r < 14) return 8'h0A;
    else if (r < 16) return 8'h0D;
    else             return ill[$urandom_range(0, 5)];
  endfunction

  initial forever begin
    ev_t e;
    @(negedge clk);
    if (!rst) begin
      if (err) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_err: err=1, required no event pending");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_err", 1, e.is_err);
        end
      end
      if (op_valid) check("ready_low_in_out", char_ready, 0);
      if (op_valid && op_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_pair: x=%0d y=%0d, required no event pending", op_x, op_y);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_pair", 0, e.is_err);
          check("pair_op_x", op_x, e.x);
          check("pair_op_y", op_y, e.y);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    @(posedge clk);
    #2;
    apply_reset();

    // basic pair with immediate hand-off
    op_ready = 1'b1;
    send_str("23\n07\n");
    check("latency_op_valid", op_valid, 1);
    @(posedge clk);
    #2;
    check("handoff_op_valid", op_valid, 0);
    check("handoff_char_ready", char_ready, 1);

    // backpressure: pair held, next char waits for the handshake
    op_ready = 1'b0;
    send_str("3\r9\n");
    fork
      send_char("1");
      begin
        for (int i = 0; i < 5; i++) begin
          check("hold_op_valid", op_valid, 1);
          check("hold_char_ready", char_ready, 0);
          check("hold_op_x", op_x, 3);
          check("hold_op_y", op_y, 9);
          @(posedge clk);
          #2;
        end
        op_ready = 1'b1;
      end
    join
    check("pending_after_handshake", acc_cyc > hs_cyc, 1);
    send_str("\n2\n");

    // third digit rejected
    send_str("123");
    check("third_digit_err", err, 1);
    @(posedge clk);
    #2;
    check("err_one_cycle", err, 0);
    send_str("4\n");
    check("x_after_err", op_x, 4);
    send_str("5\n");

    // out-of-range operand
    send_str("45\n");
    check("range_op_x", op_x, RANGE_CHECK ? 4 : 13);
    check("range_err", err, RANGE_CHECK);
    if (RANGE_CHECK) send_str("6\n");
    send_str("7\n");

    // illegal char while parsing Y keeps committed X
    send_str("10\nA");
    check("illegal_err", err, 1);
    check("illegal_keeps_x", op_x, 10);
    send_str("1\n");

    // reset mid-operand
    send_str("1");
    apply_reset();
    send_str("2\n2\n");

    // random stream with random downstream readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) send_char(rand_char());
    rand_rdy = 1'b0;
    op_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
